ro_pair_counter: RTL and testbench
==================================

# ro_pair_counter

Measurement controller for the ring-oscillator PUF. It sits on the consuming side of the two 16:1 oscillator-select multiplexers. For each request it drives both 4-bit select buses from a challenge byte and enables the oscillators. It then counts the rising edges of the two selected oscillator outputs over a fixed window and returns one response bit from comparing the two counts, together with the raw counts.

## Interface
Parameters:
- SETTLE, 4: cycles the oscillators run with counting disabled, before the window opens (≥1).
- WINDOW, 1024: length of the counting window, in clk cycles (≥1).
- CNT_W, 16: width of each edge counter.

Ports:
- clk  in  1  system clock; everything is in this domain except ro_a and ro_b.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- challenge  in  8  [7:4] selects oscillator A, [3:0] selects oscillator B.
- sel_a  out  4  select bus to mux A.
- sel_b  out  4  select bus to mux B.
- ro_en  out  1  oscillator enable.
- ro_a  in  1  output of mux A; asynchronous.
- ro_b  in  1  output of mux B; asynchronous.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when a result is valid.
- response  out  1  1 when cnt_a > cnt_b, else 0.
- tie  out  1  1 when cnt_a == cnt_b.
- cnt_a  out  CNT_W  edge count of oscillator A from the last measurement.
- cnt_b  out  CNT_W  edge count of oscillator B from the last measurement.

## Operation
- Reset values: every output is 0, and the state is IDLE.
- Synchronisation: ro_a and ro_b each pass through a 2-FF synchronizer, then a rising-edge detector (sync2 & ~sync3). Each produces a one-cycle pulse per rising edge.
- States: IDLE → SETTLE → COUNT → COMPARE → IDLE.
- IDLE:
  - On start=1, register challenge into sel_a and sel_b.
  - Clear both counters.
  - Load the timer with SETTLE−1 and go to SETTLE.
  - start is ignored in every other state; there is no queueing.
- SETTLE:
  - ro_en=1.
  - Edge pulses are not counted.
  - When the timer reaches 0, load it with WINDOW−1 and go to COUNT.
- COUNT:
  - ro_en=1.
  - Each edge pulse increments its own counter.
  - Counters saturate at 2^CNT_W−1 and do not wrap.
  - When the timer reaches 0, go to COMPARE. Pulses present in this final cycle are counted.
- COMPARE:
  - ro_en=0.
  - Set response = (cnt_a > cnt_b) and tie = (cnt_a == cnt_b).
  - Pulse done, then return to IDLE.
- Between measurements, response, tie, cnt_a, cnt_b, sel_a and sel_b hold their last values.
- sel_a == sel_b is legal: both counters see the same oscillator, normally tie=1 and response=0. No special case is needed.
- Constraint on the environment: ro_a and ro_b must toggle at less than clk/2, otherwise edges are lost. This is not detected.

## Timing
- Start accepted at rising edge T (the IDLE→SETTLE transition):
  - sel_a, sel_b valid, busy=1 and ro_en=1 from T.
  - SETTLE occupies T … T+SETTLE−1.
  - COUNT occupies T+SETTLE … T+SETTLE+WINDOW−1.
  - COMPARE occupies T+SETTLE+WINDOW. done=1, response, tie and counts are valid, and ro_en=0 in that cycle.
  - IDLE is entered at T+SETTLE+WINDOW+1, with busy=0.
- Total latency from start to done is SETTLE+WINDOW cycles after acceptance. The next start can be accepted in the first IDLE cycle.
- Synchronizer latency means an edge near the start of COUNT may produce its pulse up to 3 cycles late. Only pulses present while state==COUNT are counted.
- rst asserted mid-measurement: immediate return to IDLE with all outputs 0. No done pulse.
- start held high continuously: back-to-back measurements, one cycle of IDLE between them.

## Test plan
- Reset check: assert rst mid-COUNT → all outputs 0 within the same cycle, IDLE, busy=0; no done afterwards.
- Basic compare, SETTLE=4, WINDOW=1024, challenge=8'h3A:
  - Stimulus: ro_a period 8 clk, ro_b period 10 clk.
  - Required: sel_a=3, sel_b=10; done exactly 1028 cycles after acceptance; cnt_a=128±1, cnt_b=102±1; response=1, tie=0.
- Swapped rates: ro_a period 10, ro_b period 8 → response=0, tie=0.
- Tie: challenge=8'h55, with ro_a and ro_b driven identically at period 6 → cnt_a==cnt_b, tie=1, response=0.
- Saturation: CNT_W=4, WINDOW=64, ro_a period 3 → cnt_a=15 (no wrap); ro_b held low gives cnt_b=0; response=1.
- Protocol:
  - start pulsed while busy → ignored, sel_a and sel_b unchanged.
  - start held high → successive done pulses spaced SETTLE+WINDOW+1 cycles apart.
  - ro_a toggling during SETTLE only → cnt_a=0.

Source files
------------

// File: rtl/ro_pair_counter.sv
// Ring-oscillator PUF measurement controller: selects two oscillators, counts their
// synchronised rising edges over a fixed window and returns the comparison result.
module ro_pair_counter #(
   parameter int unsigned SETTLE = 4,
   parameter int unsigned WINDOW = 1024,
   parameter int unsigned CNT_W  = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic [7:0]       challenge_i,
   output logic [3:0]       sel_a_o,
   output logic [3:0]       sel_b_o,
   output logic             ro_en_o,
   input  logic             ro_a_i,
   input  logic             ro_b_i,
   output logic             busy_o,
   output logic             done_o,
   output logic             response_o,
   output logic             tie_o,
   output logic [CNT_W-1:0] cnt_a_o,
   output logic [CNT_W-1:0] cnt_b_o
);

   localparam int unsigned TMax = (WINDOW > SETTLE) ? WINDOW : SETTLE;
   localparam int unsigned TW   = $clog2(TMax) + 1;

   localparam logic [TW-1:0]    TimerOne   = TW'(1);
   localparam logic [TW-1:0]    SettleLoad = TW'(SETTLE - 1);
   localparam logic [TW-1:0]    WindowLoad = TW'(WINDOW - 1);
   localparam logic [CNT_W-1:0] CntOne     = CNT_W'(1);
   localparam logic [CNT_W-1:0] CntMax     = '1;

   typedef enum logic [1:0] {StIdle, StSettle, StCount, StCompare} state_e;

   state_e           state_q, state_d;
   logic [TW-1:0]    timer_q, timer_d;
   logic [3:0]       sel_a_q, sel_a_d;
   logic [3:0]       sel_b_q, sel_b_d;
   logic [CNT_W-1:0] acc_a_q, acc_a_d;
   logic [CNT_W-1:0] acc_b_q, acc_b_d;
   logic [CNT_W-1:0] cnt_a_q, cnt_a_d;
   logic [CNT_W-1:0] cnt_b_q, cnt_b_d;
   logic             resp_q, resp_d;
   logic             tie_q, tie_d;
   logic [2:0]       sync_a_q, sync_b_q;
   logic             pulse_a, pulse_b;

   // Bits [1:0] form the synchronizer; bit 2 is the delayed copy for edge detection.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_a_q <= '0;
         sync_b_q <= '0;
      end else begin
         sync_a_q <= {sync_a_q[1:0], ro_a_i};
         sync_b_q <= {sync_b_q[1:0], ro_b_i};
      end
   end

   assign pulse_a = sync_a_q[1] & ~sync_a_q[2];
   assign pulse_b = sync_b_q[1] & ~sync_b_q[2];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         timer_q <= '0;
         sel_a_q <= '0;
         sel_b_q <= '0;
         acc_a_q <= '0;
         acc_b_q <= '0;
         cnt_a_q <= '0;
         cnt_b_q <= '0;
         resp_q  <= 1'b0;
         tie_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         sel_a_q <= sel_a_d;
         sel_b_q <= sel_b_d;
         acc_a_q <= acc_a_d;
         acc_b_q <= acc_b_d;
         cnt_a_q <= cnt_a_d;
         cnt_b_q <= cnt_b_d;
         resp_q  <= resp_d;
         tie_q   <= tie_d;
      end
   end

   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      sel_a_d = sel_a_q;
      sel_b_d = sel_b_q;
      acc_a_d = acc_a_q;
      acc_b_d = acc_b_q;
      cnt_a_d = cnt_a_q;
      cnt_b_d = cnt_b_q;
      resp_d  = resp_q;
      tie_d   = tie_q;
      unique case (state_q)
         StIdle: begin
            if (start_i) begin
               sel_a_d = challenge_i[7:4];
               sel_b_d = challenge_i[3:0];
               acc_a_d = '0;
               acc_b_d = '0;
               timer_d = SettleLoad;
               state_d = StSettle;
            end
         end
         StSettle: begin
            if (timer_q == '0) begin
               timer_d = WindowLoad;
               state_d = StCount;
            end else begin
               timer_d = timer_q - TimerOne;
            end
         end
         StCount: begin
            if (pulse_a && (acc_a_q != CntMax)) acc_a_d = acc_a_q + CntOne;
            if (pulse_b && (acc_b_q != CntMax)) acc_b_d = acc_b_q + CntOne;
            // Results are captured from the final-cycle totals so they are valid during
            // COMPARE and hold across the next measurement's counter clear.
            if (timer_q == '0) begin
               cnt_a_d = acc_a_d;
               cnt_b_d = acc_b_d;
               resp_d  = acc_a_d > acc_b_d;
               tie_d   = acc_a_d == acc_b_d;
               state_d = StCompare;
            end else begin
               timer_d = timer_q - TimerOne;
            end
         end
         StCompare: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   assign sel_a_o    = sel_a_q;
   assign sel_b_o    = sel_b_q;
   assign ro_en_o    = (state_q == StSettle) || (state_q == StCount);
   assign busy_o     = state_q != StIdle;
   assign done_o     = state_q == StCompare;
   assign response_o = resp_q;
   assign tie_o      = tie_q;
   assign cnt_a_o    = cnt_a_q;
   assign cnt_b_o    = cnt_b_q;

endmodule

// File: tb/tb_ro_pair_counter.sv
// Directed bench for ro_pair_counter: a default instance and a narrow saturating one
// share the oscillator stimulus; expected values are hand-derived constants.
module tb_ro_pair_counter;

   logic        clk;
   logic        rst;
   logic        start;
   logic        start_s;
   logic [7:0]  challenge;
   logic        ro_a;
   logic        ro_b;
   logic        ro_b_w;
   logic        ro_same;
   logic        ro_a_man, ro_b_man;
   int          ro_a_half, ro_b_half;

   logic [3:0]  sel_a, sel_b, sel_a_s, sel_b_s;
   logic        ro_en, busy, done, response, tie;
   logic        ro_en_s, busy_s, done_s, response_s, tie_s;
   logic [15:0] cnt_a, cnt_b;
   logic [3:0]  cnt_a_s, cnt_b_s;

   int checks;
   int failures;

   ro_pair_counter #(.SETTLE(4), .WINDOW(1024), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .start_i(start), .challenge_i(challenge),
      .sel_a_o(sel_a), .sel_b_o(sel_b), .ro_en_o(ro_en), .ro_a_i(ro_a), .ro_b_i(ro_b_w),
      .busy_o(busy), .done_o(done), .response_o(response), .tie_o(tie),
      .cnt_a_o(cnt_a), .cnt_b_o(cnt_b)
   );

   ro_pair_counter #(.SETTLE(4), .WINDOW(64), .CNT_W(4)) dut_sat (
      .clk(clk), .rst(rst), .start_i(start_s), .challenge_i(challenge),
      .sel_a_o(sel_a_s), .sel_b_o(sel_b_s), .ro_en_o(ro_en_s), .ro_a_i(ro_a), .ro_b_i(ro_b_w),
      .busy_o(busy_s), .done_o(done_s), .response_o(response_s), .tie_o(tie_s),
      .cnt_a_o(cnt_a_s), .cnt_b_o(cnt_b_s)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Oscillator models: half-period in ns, 0 means follow the manual level.
   initial begin
      ro_a = 1'b0;
      #2;
      forever begin
         if (ro_a_half == 0) begin
            ro_a = ro_a_man;
            #1;
         end else begin
            #(ro_a_half);
            ro_a = ~ro_a;
         end
      end
   end

   initial begin
      ro_b = 1'b0;
      #2;
      forever begin
         if (ro_b_half == 0) begin
            ro_b = ro_b_man;
            #1;
         end else begin
            #(ro_b_half);
            ro_b = ~ro_b;
         end
      end
   end

   assign ro_b_w = ro_same ? ro_a : ro_b;

   // Returns k = cycles from the acceptance cycle to the done cycle, or -1 on timeout.
   task automatic wait_done(input bit sat, input int budget, output int k);
      bit seen;
      k = 0;
      seen = 1'b0;
      while (!seen && k <= budget) begin
         @(negedge clk);
         if ((sat ? done_s : done) === 1'b1) seen = 1'b1;
         else k++;
      end
      if (!seen) k = -1;
   endtask

   task automatic start_pulse(input bit sat, input logic [7:0] ch);
      @(negedge clk);
      challenge = ch;
      if (sat) start_s = 1'b1;
      else start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      start_s = 1'b0;
   endtask

   task automatic test_reset_state;
      rst = 1'b1;
      #1;
      checks++;
      if ({sel_a, sel_b, ro_en, busy, done, response, tie, cnt_a, cnt_b} !== '0) begin
         failures++;
         $display("FAIL reset_state: outputs=%h required 0",
                  {sel_a, sel_b, ro_en, busy, done, response, tie, cnt_a, cnt_b});
      end
      repeat (3) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_basic;
      int k;
      ro_same = 1'b0; ro_a_half = 40; ro_b_half = 50;
      repeat (20) @(negedge clk);
      start_pulse(1'b0, 8'h3A);
      checks++;
      if (sel_a !== 4'd3 || sel_b !== 4'd10) begin
         failures++;
         $display("FAIL basic_sel: sel_a=%0d sel_b=%0d required 3/10", sel_a, sel_b);
      end
      checks++;
      if (busy !== 1'b1 || ro_en !== 1'b1) begin
         failures++;
         $display("FAIL basic_busy: busy=%b ro_en=%b required 1/1", busy, ro_en);
      end
      wait_done(1'b0, 1200, k);
      checks++;
      if (k != 1028) begin
         failures++;
         $display("FAIL basic_latency: got %0d required 1028", k);
      end
      checks++;
      if (cnt_a < 16'd127 || cnt_a > 16'd129 || cnt_b < 16'd101 || cnt_b > 16'd103) begin
         failures++;
         $display("FAIL basic_counts: cnt_a=%0d cnt_b=%0d required 128+-1/102+-1", cnt_a, cnt_b);
      end
      checks++;
      if (response !== 1'b1 || tie !== 1'b0 || ro_en !== 1'b0) begin
         failures++;
         $display("FAIL basic_result: response=%b tie=%b ro_en=%b required 1/0/0",
                  response, tie, ro_en);
      end
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || response !== 1'b1) begin
         failures++;
         $display("FAIL basic_idle: busy=%b done=%b response=%b required 0/0/1",
                  busy, done, response);
      end
   endtask

   task automatic test_swapped;
      int k;
      ro_a_half = 50; ro_b_half = 40;
      repeat (10) @(negedge clk);
      start_pulse(1'b0, 8'hA3);
      wait_done(1'b0, 1200, k);
      checks++;
      if (k != 1028 || response !== 1'b0 || tie !== 1'b0) begin
         failures++;
         $display("FAIL swapped: latency=%0d response=%b tie=%b required 1028/0/0",
                  k, response, tie);
      end
      checks++;
      if (cnt_a < 16'd101 || cnt_a > 16'd103 || cnt_b < 16'd127 || cnt_b > 16'd129) begin
         failures++;
         $display("FAIL swapped_counts: cnt_a=%0d cnt_b=%0d required 102+-1/128+-1",
                  cnt_a, cnt_b);
      end
   endtask

   task automatic test_tie;
      int k;
      ro_a_half = 30; ro_same = 1'b1;
      repeat (10) @(negedge clk);
      start_pulse(1'b0, 8'h55);
      checks++;
      if (sel_a !== 4'd5 || sel_b !== 4'd5) begin
         failures++;
         $display("FAIL tie_sel: sel_a=%0d sel_b=%0d required 5/5", sel_a, sel_b);
      end
      wait_done(1'b0, 1200, k);
      checks++;
      if (tie !== 1'b1 || response !== 1'b0 || cnt_a !== cnt_b) begin
         failures++;
         $display("FAIL tie: tie=%b response=%b cnt_a=%0d cnt_b=%0d required 1/0/equal",
                  tie, response, cnt_a, cnt_b);
      end
      checks++;
      if (cnt_a < 16'd169 || cnt_a > 16'd172) begin
         failures++;
         $display("FAIL tie_count: cnt_a=%0d required 170..171 (+-1)", cnt_a);
      end
      ro_same = 1'b0;
   endtask

   task automatic test_saturation;
      int k;
      ro_a_half = 15; ro_b_half = 0; ro_b_man = 1'b0;
      repeat (10) @(negedge clk);
      start_pulse(1'b1, 8'hC0);
      wait_done(1'b1, 200, k);
      checks++;
      if (k != 68) begin
         failures++;
         $display("FAIL sat_latency: got %0d required 68", k);
      end
      checks++;
      if (cnt_a_s !== 4'd15 || cnt_b_s !== 4'd0 || response_s !== 1'b1 || tie_s !== 1'b0) begin
         failures++;
         $display("FAIL saturation: cnt_a=%0d cnt_b=%0d response=%b tie=%b required 15/0/1/0",
                  cnt_a_s, cnt_b_s, response_s, tie_s);
      end
   endtask

   task automatic test_busy_ignore;
      int k;
      ro_a_half = 40; ro_b_half = 50;
      repeat (10) @(negedge clk);
      start_pulse(1'b0, 8'h12);
      repeat (10) @(negedge clk);
      start_pulse(1'b0, 8'hEF);
      checks++;
      if (sel_a !== 4'd1 || sel_b !== 4'd2 || busy !== 1'b1) begin
         failures++;
         $display("FAIL busy_ignore_sel: sel_a=%0d sel_b=%0d busy=%b required 1/2/1",
                  sel_a, sel_b, busy);
      end
      // Stray start sampled at acceptance+11; done must still land at acceptance+1028.
      wait_done(1'b0, 1200, k);
      checks++;
      if (k != 1017) begin
         failures++;
         $display("FAIL busy_ignore_latency: got %0d required 1017", k);
      end
   endtask

   task automatic test_settle_only;
      int k;
      ro_a_half = 0; ro_b_half = 0; ro_a_man = 1'b0; ro_b_man = 1'b0;
      repeat (10) @(negedge clk);
      start_pulse(1'b0, 8'h77);
      ro_a_man = 1'b1;  // single rising edge early in SETTLE
      repeat (3) @(negedge clk);
      ro_a_man = 1'b0;
      wait_done(1'b0, 1200, k);
      checks++;
      if (cnt_a !== 16'd0 || cnt_b !== 16'd0 || tie !== 1'b1 || response !== 1'b0) begin
         failures++;
         $display("FAIL settle_only: cnt_a=%0d cnt_b=%0d tie=%b response=%b required 0/0/1/0",
                  cnt_a, cnt_b, tie, response);
      end
   endtask

   task automatic test_back_to_back;
      int k;
      ro_a_half = 40; ro_b_half = 50;
      repeat (10) @(negedge clk);
      challenge = 8'h21;
      start = 1'b1;
      wait_done(1'b0, 1200, k);
      checks++;
      if (k < 0) begin
         failures++;
         $display("FAIL b2b_first: no done within budget, got %0d required >=0", k);
      end
      // Next done should follow after SETTLE+WINDOW+1 intervening cycles.
      wait_done(1'b0, 1200, k);
      start = 1'b0;
      checks++;
      if (k != 1029) begin
         failures++;
         $display("FAIL b2b_spacing: got %0d required 1029", k);
      end
      checks++;
      if (sel_a !== 4'd2 || sel_b !== 4'd1 || response !== 1'b1) begin
         failures++;
         $display("FAIL b2b_result: sel_a=%0d sel_b=%0d response=%b required 2/1/1",
                  sel_a, sel_b, response);
      end
      repeat (2) @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         failures++;
         $display("FAIL b2b_stop: busy=%b done=%b required 0/0", busy, done);
      end
   endtask

   task automatic test_reset_mid_count;
      int k;
      start_pulse(1'b0, 8'h3A);
      repeat (20) @(negedge clk);
      checks++;
      if (busy !== 1'b1 || ro_en !== 1'b1) begin
         failures++;
         $display("FAIL rst_pre: busy=%b ro_en=%b required 1/1", busy, ro_en);
      end
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if ({sel_a, sel_b, ro_en, busy, done, response, tie, cnt_a, cnt_b} !== '0) begin
         failures++;
         $display("FAIL rst_mid: outputs=%h required 0",
                  {sel_a, sel_b, ro_en, busy, done, response, tie, cnt_a, cnt_b});
      end
      @(negedge clk);
      rst = 1'b0;
      wait_done(1'b0, 1100, k);
      checks++;
      if (k != -1) begin
         failures++;
         $display("FAIL rst_no_done: done seen after %0d cycles, required none", k);
      end
   endtask

   initial begin
      checks = 0; failures = 0;
      rst = 1'b1; start = 1'b0; start_s = 1'b0; challenge = 8'h00;
      ro_same = 1'b0; ro_a_man = 1'b0; ro_b_man = 1'b0;
      ro_a_half = 0; ro_b_half = 0;
      test_reset_state();
      test_basic();
      test_swapped();
      test_tie();
      test_saturation();
      test_busy_ignore();
      test_settle_only();
      test_back_to_back();
      test_reset_mid_count();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
